// File: rtl/countdown_timer_if.sv
// Load handshake, run controls and status outputs of the countdown timer.
// The master drives loads and controls; the slave (the timer) drives status.
interface countdown_timer_if #(
    parameter int unsigned WIDTH = 8
);
    logic             load_valid;
    logic [WIDTH-1:0] load_value;
    logic             load_ready;
    logic             enable;
    logic             auto_reload;
    logic             abort;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             done;
    logic [7:0]       expire_count;

    modport master (
        output load_valid, load_value, enable, auto_reload, abort,
        input  load_ready, count, busy, done, expire_count
    );

    modport slave (
        input  load_valid, load_value, enable, auto_reload, abort,
        output load_ready, count, busy, done, expire_count
    );
endinterface

// File: rtl/countdown_timer.sv
// Loadable down-counter with one-cycle expiry pulse, optional auto-reload,
// abort, and a free-running 8-bit expiry tally.
module countdown_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    countdown_timer_if.slave  tmr
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        EXPIRE
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic [7:0]       expire_cnt_q, expire_cnt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            count_q      <= '0;
            reload_q     <= '0;
            expire_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            reload_q     <= reload_d;
            expire_cnt_q <= expire_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        reload_d     = reload_q;
        expire_cnt_d = expire_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (tmr.load_valid) begin
                    reload_d = tmr.load_value;
                    count_d  = tmr.load_value;
                    state_d  = (tmr.load_value != '0) ? RUN : EXPIRE;
                end
            end

            RUN: begin
                if (tmr.abort) begin
                    state_d = IDLE;
                    count_d = '0;
                end else if (tmr.enable) begin
                    // count<=1 lands on 0 in EXPIRE, so the decrement never wraps
                    if (count_q <= WIDTH'(1)) begin
                        count_d = '0;
                        state_d = EXPIRE;
                    end else begin
                        count_d = count_q - WIDTH'(1);
                    end
                end
            end

            EXPIRE: begin
                expire_cnt_d = expire_cnt_q + 8'd1;
                if (tmr.abort || !tmr.auto_reload) begin
                    state_d = IDLE;
                    count_d = '0;
                end else if (reload_q != '0) begin
                    state_d = RUN;
                    count_d = reload_q;
                end else begin
                    state_d = EXPIRE;
                    count_d = '0;
                end
            end

            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase
    end

    assign tmr.load_ready   = (state_q == IDLE);
    assign tmr.busy         = (state_q != IDLE);
    assign tmr.done         = (state_q == EXPIRE);
    assign tmr.count        = count_q;
    assign tmr.expire_count = expire_cnt_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Randomized and directed stimulus for countdown_timer, checked every cycle
// against a behavioural model of the timer rules.
module tb_countdown_timer;

    localparam int unsigned WIDTH = 8;

    localparam int M_IDLE   = 0;
    localparam int M_RUN    = 1;
    localparam int M_EXPIRE = 2;

    logic clk;
    logic reset;

    countdown_timer_if #(.WIDTH(WIDTH)) tmr ();

    countdown_timer #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .tmr   (tmr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_vec;
    int unsigned n_err;

    // reference model state
    int         m_mode;
    logic [7:0] m_count;
    logic [7:0] m_reload;
    logic [7:0] m_tally;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d, want %0d", tag, $time, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic lv, input logic [7:0] val,
                         input logic en, input logic ar, input logic ab);
        reset           = rst;
        tmr.load_valid  = lv;
        tmr.load_value  = val;
        tmr.enable      = en;
        tmr.auto_reload = ar;
        tmr.abort       = ab;
    endtask

    task automatic model_step();
        if (reset) begin
            m_mode = M_IDLE; m_count = 0; m_reload = 0; m_tally = 0;
        end else if (m_mode == M_IDLE) begin
            if (tmr.load_valid) begin
                m_reload = tmr.load_value;
                m_count  = tmr.load_value;
                m_mode   = (tmr.load_value == 0) ? M_EXPIRE : M_RUN;
            end
        end else if (m_mode == M_RUN) begin
            if (tmr.abort) begin
                m_mode = M_IDLE; m_count = 0;
            end else if (tmr.enable) begin
                m_count = m_count - 8'd1;
                if (m_count == 0) m_mode = M_EXPIRE;
            end
        end else begin
            m_tally = m_tally + 8'd1;
            if (tmr.abort || !tmr.auto_reload) begin
                m_mode = M_IDLE; m_count = 0;
            end else if (m_reload != 0) begin
                m_mode = M_RUN; m_count = m_reload;
            end
        end
    endtask

    // compare outputs mid-cycle, then advance the model across the next edge
    task automatic tick();
        @(negedge clk);
        check("load_ready", 32'(tmr.load_ready), 32'(m_mode == M_IDLE));
        check("busy", 32'(tmr.busy), 32'(m_mode != M_IDLE));
        check("done", 32'(tmr.done), 32'(m_mode == M_EXPIRE));
        check("count", 32'(tmr.count), 32'(m_count));
        check("expire_count", 32'(tmr.expire_count), 32'(m_tally));
        @(posedge clk);
        model_step();
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        m_mode = M_IDLE; m_count = 0; m_reload = 0; m_tally = 0;

        drive(1'b1, 1'b1, 8'd9, 1'b1, 1'b1, 1'b1);
        @(posedge clk);
        model_step();
        #1;
        tick();
        check("rst_ready", 32'(tmr.load_ready), 32'd1);
        check("rst_count", 32'(tmr.count), 32'd0);

        // load 3, no reload: 3,2,1,0 then idle with tally 1
        drive(1'b0, 1'b1, 8'd3, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
        repeat (5) tick();
        check("once_tally", 32'(tmr.expire_count), 32'd1);

        // load 2 with auto-reload for nine cycles
        drive(1'b0, 1'b1, 8'd2, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0);
        repeat (9) tick();
        drive(1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b1);
        tick();
        check("reload_tally", 32'(tmr.expire_count), 32'd4);

        // load 5, enable 1,0,0,1 with ignored load offers while busy
        drive(1'b0, 1'b1, 8'd5, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b1, 8'd77, 1'b1, 1'b0, 1'b0); tick();
        drive(1'b0, 1'b1, 8'd77, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b0, 1'b1, 8'd77, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b0, 1'b0, 8'd0,  1'b1, 1'b0, 1'b0); tick();
        check("hold_count", 32'(tmr.count), 32'd3);
        // abort at count 2
        tick();
        drive(1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1);
        tick();
        drive(1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
        repeat (2) tick();

        // zero-length timer
        drive(1'b0, 1'b1, 8'd0, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
        repeat (3) tick();

        // reset mid-countdown
        drive(1'b0, 1'b1, 8'd8, 1'b1, 1'b0, 1'b0);
        repeat (5) tick();
        drive(1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
        tick();
        check("mid_rst_ready", 32'(tmr.load_ready), 32'd1);

        // zero reload with auto-reload: tally wraps after 256 expiries
        drive(1'b0, 1'b1, 8'd0, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0);
        repeat (256) tick();
        check("wrap_tally", 32'(tmr.expire_count), 32'd0);
        drive(1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1);
        repeat (2) tick();

        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 59) == 0),
                  ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 6)),
                  ($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 1)),
                  ($urandom_range(0, 24) == 0));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
